// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: ALU encodings, opcodes,
// the XM pipeline-register payload, reset values and small helpers.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned CTR_W  = 3;
    localparam int unsigned SQ_W   = 2;
    localparam int unsigned OP_W   = 6;

    // ALUctr encodings
    localparam logic [CTR_W-1:0] ALU_ADD = 3'b000;
    localparam logic [CTR_W-1:0] ALU_SUB = 3'b001;
    localparam logic [CTR_W-1:0] ALU_AND = 3'b010;
    localparam logic [CTR_W-1:0] ALU_OR  = 3'b011;
    localparam logic [CTR_W-1:0] ALU_SLT = 3'b100;
    localparam logic [CTR_W-1:0] ALU_BEQ = 3'b101;
    localparam logic [CTR_W-1:0] ALU_BNE = 3'b110;
    localparam logic [CTR_W-1:0] ALU_NOP = 3'b111;

    // Primary opcodes decoded upstream
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

    // XM pipeline register payload
    typedef struct packed {
        logic              memto_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [REG_W-1:0]  rd;
        logic [WORD_W-1:0] alu_out;
        logic [WORD_W-1:0] md;
        logic [WORD_W-1:0] bt;
        logic              redirect;
    } xm_t;

    // Reset values
    localparam xm_t             XM_RST     = '0;
    localparam logic [SQ_W-1:0] SQ_CNT_RST = '0;

    // Word-aligned, sign-extended branch displacement
    function automatic logic [WORD_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{14{imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/alu32.sv
// 32-bit combinational ALU with equality flag; wrap-around arithmetic.
module alu32
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic [CTR_W-1:0]  ALUctr,
    output logic [WORD_W-1:0] result,
    output logic              zero
);

    // Operation select; unused encoding yields 0
    always_comb begin
        result = '0;
        case (ALUctr)
            ALU_ADD: result = A + B;
            ALU_SUB: result = A - B;
            ALU_AND: result = A & B;
            ALU_OR:  result = A | B;
            ALU_SLT: result = {31'b0, ($signed(A) < $signed(B))};
            ALU_BEQ: result = A - B;
            ALU_BNE: result = A - B;
            default: result = '0;
        endcase
    end

    assign zero = (A == B);

endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU, beq/bne/j resolution, wrong-path squash, XM register.
module execute_stage
    import mips_pkg::*;
#(
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              branch,
    input  logic              jump,
    input  logic [CTR_W-1:0]  ALUctr,
    input  logic [WORD_W-1:0] JT,
    input  logic [WORD_W-1:0] NPC,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic [IMM_W-1:0]  imm,
    input  logic [REG_W-1:0]  RD,
    input  logic [WORD_W-1:0] MD,
    output logic              XM_MemtoReg,
    output logic              XM_RegWrite,
    output logic              XM_MemRead,
    output logic              XM_MemWrite,
    output logic [REG_W-1:0]  XM_RD,
    output logic [WORD_W-1:0] ALUout,
    output logic [WORD_W-1:0] XM_MD,
    output logic [WORD_W-1:0] XM_BT,
    output logic              XM_redirect,
    output logic              squashing
);

    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CYCLES);

    logic [WORD_W-1:0] alu_result;
    logic              alu_zero;
    logic [WORD_W-1:0] br_target;
    logic              taken;
    logic              squash_active;
    logic [SQ_W-1:0]   sq_cnt;
    logic [SQ_W-1:0]   sq_cnt_d;
    xm_t               xm_d;
    xm_t               xm_q;

    alu32 u_alu (
        .A      (A),
        .B      (B),
        .ALUctr (ALUctr),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign squash_active = (sq_cnt != '0);

    // Redirect resolution and next XM payload; squash gates side effects only
    always_comb begin
        br_target = NPC + branch_offset(imm);
        taken     = jump
                  | (branch & (ALUctr == ALU_BEQ) &  alu_zero)
                  | (branch & (ALUctr == ALU_BNE) & ~alu_zero);

        xm_d           = XM_RST;
        xm_d.memto_reg = MemtoReg;
        xm_d.reg_write = RegWrite & ~squash_active;
        xm_d.mem_read  = MemRead  & ~squash_active;
        xm_d.mem_write = MemWrite & ~squash_active;
        xm_d.rd        = RD;
        xm_d.alu_out   = alu_result;
        xm_d.md        = MD;
        xm_d.bt        = jump ? JT : br_target;
        xm_d.redirect  = taken & ~squash_active;
    end

    // Squash counter: count down while active, load only on a live redirect
    always_comb begin
        sq_cnt_d = sq_cnt;
        if (squash_active) begin
            sq_cnt_d = sq_cnt - SQ_W'(1);
        end else if (taken) begin
            sq_cnt_d = SQ_LOAD;
        end
    end

    // XM pipeline register and squash counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xm_q   <= XM_RST;
            sq_cnt <= SQ_CNT_RST;
        end else begin
            xm_q   <= xm_d;
            sq_cnt <= sq_cnt_d;
        end
    end

    assign XM_MemtoReg = xm_q.memto_reg;
    assign XM_RegWrite = xm_q.reg_write;
    assign XM_MemRead  = xm_q.mem_read;
    assign XM_MemWrite = xm_q.mem_write;
    assign XM_RD       = xm_q.rd;
    assign ALUout      = xm_q.alu_out;
    assign XM_MD       = xm_q.md;
    assign XM_BT       = xm_q.bt;
    assign XM_redirect = xm_q.redirect;
    assign squashing   = squash_active;

endmodule
